// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared constants and helpers for the router datapath (FSM, FIFOs, sync).
//   MAX_PORTS       : largest supported number of output ports/FIFOs
//   DEFAULT_TIMEOUT : default stall cycles before a FIFO soft reset
//   addr_width()    : header address field width for a given port count
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int MAX_PORTS       = 16;
  localparam int DEFAULT_TIMEOUT = 30;

  // Width of the address field; never narrower than one bit.
  function automatic int addr_width(input int num_ports);
    if (num_ports <= 2) begin
      return 1;
    end else begin
      return $clog2(num_ports);
    end
  endfunction

endpackage : router_pkg

// File: rtl/router_stall_timer.sv
// -----------------------------------------------------------------------------
// router_stall_timer
// One output port's stall-timeout counter. Counts consecutive stalled cycles
// and emits a registered one-cycle soft reset when the TIMEOUT-th consecutive
// stalled cycle has been seen, then restarts from zero.
// Ports:
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   stall_i      in   port has valid data that the reader is not taking
//   soft_reset_o out  one-cycle soft reset pulse to the port's FIFO
// -----------------------------------------------------------------------------
module router_stall_timer
  import router_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic resetn,
  input  logic stall_i,
  output logic soft_reset_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pulse_q;
  logic             pulse_d;

  // Next-state for the stall counter and its expiry pulse.
  always_comb begin
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (stall_i) begin
      // >= rather than == so a corrupted count can never run past the limit.
      if (cnt_q >= CNT_LAST) begin
        cnt_d   = '0;
        pulse_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        pulse_d = 1'b0;
      end
    end else begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end
  end

  // Counter and pulse registers; reset clears both immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign soft_reset_o = pulse_q;

endmodule : router_stall_timer

// File: rtl/router_sync_n.sv
// -----------------------------------------------------------------------------
// router_sync_n
// Parametrised router synchronizer between the router FSM/register block and
// NUM_PORTS output FIFOs. Latches the header destination address, decodes it
// into one-hot FIFO write enables, muxes the addressed FIFO's full flag,
// drives per-port valid, and runs one stall-timeout timer per port.
// Ports:
//   clk           in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   detect_add    in   header present; latch data_in on this edge
//   write_enb_reg in   FSM write strobe for the current packet
//   data_in       in   [ADDR_W]    destination address from header
//   read_enb      in   [NUM_PORTS] per-port reader read strobe
//   full          in   [NUM_PORTS] per-FIFO full
//   empty         in   [NUM_PORTS] per-FIFO empty
//   vld_out       out  [NUM_PORTS] per-port data valid (= ~empty)
//   soft_reset    out  [NUM_PORTS] registered per-FIFO soft reset pulse
//   write_enb     out  [NUM_PORTS] one-hot FIFO write enable
//   fifo_full     out  full flag of the addressed FIFO
//   addr_err      out  registered pulse: latched address out of range
// -----------------------------------------------------------------------------
module router_sync_n
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = addr_width(NUM_PORTS),
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 detect_add,
  input  logic                 write_enb_reg,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] full,
  input  logic [NUM_PORTS-1:0] empty,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic                 addr_err
);

  // One extra bit so NUM_PORTS itself is representable for the range check.
  localparam logic [ADDR_W:0] NUM_PORTS_W = (ADDR_W + 1)'(NUM_PORTS);

  logic [ADDR_W-1:0]    addr_q;
  logic [ADDR_W-1:0]    addr_d;
  logic                 addr_ok_q;
  logic                 addr_ok_d;
  logic                 addr_err_q;
  logic                 addr_err_d;
  logic                 in_range_s;
  logic [NUM_PORTS-1:0] addr_onehot_s;
  logic [NUM_PORTS-1:0] stall_s;

  assign in_range_s = ({1'b0, data_in} < NUM_PORTS_W);

  // Next-state for the address latch; addr_err is high only on a latch edge.
  always_comb begin
    addr_d     = addr_q;
    addr_ok_d  = addr_ok_q;
    addr_err_d = 1'b0;
    if (detect_add) begin
      addr_d     = data_in;
      addr_ok_d  = in_range_s;
      addr_err_d = ~in_range_s;
    end else begin
      addr_d     = addr_q;
      addr_ok_d  = addr_ok_q;
      addr_err_d = 1'b0;
    end
  end

  // Address latch registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      addr_ok_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      addr_ok_q  <= addr_ok_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Decode of the latched address; an invalid address selects no port, which
  // blocks both the write enables and the full-flag mux.
  always_comb begin
    addr_onehot_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_ok_q && (addr_q == ADDR_W'(i))) begin
        addr_onehot_s[i] = 1'b1;
      end else begin
        addr_onehot_s[i] = 1'b0;
      end
    end
  end

  // Write enable and full-flag selection from the decoded address.
  always_comb begin
    write_enb = '0;
    fifo_full = |(full & addr_onehot_s);
    if (write_enb_reg) begin
      write_enb = addr_onehot_s;
    end else begin
      write_enb = '0;
    end
  end

  assign vld_out  = ~empty;
  assign stall_s  = vld_out & ~read_enb;
  assign addr_err = addr_err_q;

  // Stall timers run per port, independent of the latched address.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
    router_stall_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clk          (clk),
      .resetn       (resetn),
      .stall_i      (stall_s[g]),
      .soft_reset_o (soft_reset[g])
    );
  end

endmodule : router_sync_n

// File: doc/router_sync_n.md
Name: router_sync_n

Overview:
- Parametrised successor to the router's three-port synchronizer.
- Latches the destination address on header detect and decodes it into one-hot FIFO write enables. Selects the addressed FIFO's full flag and drives per-port valid outputs.
- Runs an independent stall-timeout counter per output port; each port's counter issues a one-cycle soft reset to its FIFO when the reader abandons it.
- Sits between the router FSM/register block and the NUM_PORTS output FIFOs.

Parameters:
- NUM_PORTS, 3, number of output ports/FIFOs (2..16).
- ADDR_W, $clog2(NUM_PORTS), width of header address field.
- TIMEOUT, 30, consecutive stalled cycles before a soft reset (2..1023).
- CNT_W, $clog2(TIMEOUT+1), stall counter width (localparam, derived).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- detect_add  in  1  header byte present; latch data_in this cycle.
- write_enb_reg  in  1  FSM write strobe for the current packet.
- data_in  in  ADDR_W  destination address from header.
- read_enb  in  NUM_PORTS  per-port reader read strobe.
- full  in  NUM_PORTS  per-FIFO full.
- empty  in  NUM_PORTS  per-FIFO empty.
- vld_out  out  NUM_PORTS  per-port data valid.
- soft_reset  out  NUM_PORTS  per-FIFO soft reset pulse (registered).
- write_enb  out  NUM_PORTS  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the addressed FIFO.
- addr_err  out  1  one-cycle pulse: latched address was out of range.

Behaviour:
- Reset is asynchronous, active-low: addr_q=0, addr_ok=0, all stall counters=0, soft_reset=0, addr_err=0.
- Combinational outputs resolve from reset state: write_enb=0, fifo_full=0, vld_out=~empty.
- Address latch, on the clk edge with detect_add=1:
  - addr_q<=data_in.
  - addr_ok<=(data_in<NUM_PORTS).
  - addr_err<=(data_in>=NUM_PORTS); addr_err is 0 in every other cycle.
  - With detect_add=0, addr_q and addr_ok hold.
- Latency: address is usable the cycle after detect_add; same-cycle data_in is never bypassed.
- write_enb (combinational): one-hot bit addr_q when write_enb_reg=1 and addr_ok=1; otherwise all zero.
- fifo_full (combinational): full[addr_q] when addr_ok=1, else 0.
- vld_out[i] = ~empty[i], combinational.
- Stall counter, per port i, independent of addr_q:
  - stall_i = vld_out[i] & ~read_enb[i].
  - stall_i=0: cnt_i<=0, soft_reset[i]<=0.
  - stall_i=1 and cnt_i<TIMEOUT-1: cnt_i<=cnt_i+1, soft_reset[i]<=0.
  - stall_i=1 and cnt_i==TIMEOUT-1: cnt_i<=0, soft_reset[i]<=1.
  - Result: soft_reset[i] rises on the edge after the TIMEOUT-th consecutive stalled cycle and lasts exactly one cycle.
  - The counter restarts from 0 the cycle after the pulse.
  - detect_add does not clear counters.
- Boundary conditions:
  - read_enb[i]=1 on the cycle the count would expire: no pulse; counter clears.
  - FIFO goes empty mid-count: counter clears.
  - Simultaneous expiry on several ports: each pulses independently in the same cycle.
  - resetn low mid-count: counters and pulses clear immediately; no pulse is emitted on reset release.
  - detect_add with write_enb_reg=1 in the same cycle: write_enb uses the old addr_q that cycle.
  - Counter never exceeds TIMEOUT-1; no wrap.

Decomposition:
- Shared package router_pkg holds MAX_PORTS=16, DEFAULT_TIMEOUT=30 and the address width function used by the FSM and FIFOs.
- One sub-module, router_stall_timer: a single port's counter and pulse, parametrised by TIMEOUT, instantiated NUM_PORTS times in a generate loop.
- Address latch, decode and mux stay in the top level.

Test Plan:
- Reset/decode (NUM_PORTS=3): assert resetn=0 → all outputs 0 except vld_out=~empty. Release resetn, detect_add with data_in=2, next cycle write_enb_reg=1 → write_enb=3'b100; full=3'b100 → fifo_full=1.
- Invalid address (NUM_PORTS=3, ADDR_W=2): detect_add with data_in=3 → addr_err=1 for one cycle. With write_enb_reg=1 → write_enb=0 and fifo_full=0 regardless of full.
- Timeout (TIMEOUT=30): empty[1]=0, read_enb[1]=0 held → soft_reset[1]=1 exactly one cycle, on the edge after the 30th stalled cycle; second pulse 30 cycles later; ports 0/2 stay 0.
- Late read (TIMEOUT=30): stall 29 cycles, read_enb[1]=1 on cycle 30 → no pulse; fresh stall needs a full 30 cycles.
- Simultaneous expiry and mid-reset: ports 0 and 2 stalled from the same cycle → both pulse together. Repeat, and pull resetn low at cycle 20 → no pulse, counters 0 after release.
- Scaling (NUM_PORTS=8, TIMEOUT=5, ADDR_W=3): address 7 → write_enb=8'h80; port 7 stalled 5 cycles → one-cycle soft_reset[7].
